avmm_wb_bridge_fsm: RTL

Registered Avalon-MM slave to Wishbone classic master bridge. It replaces the pass-through bridge. It implements avmm_waitrequest, holds one transaction in flight, captures read data, and reports Wishbone err_i or a bus timeout through avmm_response. It sits between the system interconnect and any Wishbone peripheral, such as the custom RAM, which may take any number of cycles to acknowledge.

---
 rtl/avmm_wb_bridge_fsm_if.sv | 40 ++++
 rtl/avmm_wb_bridge_fsm.sv | 101 ++++++++++
 2 files changed

// File: rtl/avmm_wb_bridge_fsm_if.sv
// Avalon-MM slave side and Wishbone classic master side of the bridge, bundled.
// The bridge uses the slave modport; the environment (interconnect + peripheral) uses master.
interface avmm_wb_bridge_fsm_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8
);
  logic                  avmm_chipselect;
  logic [ADDR_WIDTH-1:0] avmm_address;
  logic                  avmm_read;
  logic                  avmm_write;
  logic [DATA_WIDTH-1:0] avmm_writedata;
  logic [BE_WIDTH-1:0]   avmm_byteenable;
  logic [DATA_WIDTH-1:0] avmm_readdata;
  logic                  avmm_waitrequest;
  logic [1:0]            avmm_response;
  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  we_o;
  logic [BE_WIDTH-1:0]   sel_o;
  logic                  stb_o;
  logic                  cyc_o;
  logic                  ack_i;
  logic                  err_i;

  modport slave (
    input  avmm_chipselect, avmm_address, avmm_read, avmm_write, avmm_writedata,
           avmm_byteenable, data_i, ack_i, err_i,
    output avmm_readdata, avmm_waitrequest, avmm_response, adr_o, data_o, we_o,
           sel_o, stb_o, cyc_o
  );

  modport master (
    output avmm_chipselect, avmm_address, avmm_read, avmm_write, avmm_writedata,
           avmm_byteenable, data_i, ack_i, err_i,
    input  avmm_readdata, avmm_waitrequest, avmm_response, adr_o, data_o, we_o,
           sel_o, stb_o, cyc_o
  );
endinterface

// File: rtl/avmm_wb_bridge_fsm.sv
// Registered Avalon-MM slave to Wishbone classic master bridge: one transaction in
// flight, waitrequest stalling, read capture, SLVERR / timeout reporting.
module avmm_wb_bridge_fsm #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ERRCNT_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  avmm_wb_bridge_fsm_if.slave     bus,
  output logic [ERRCNT_WIDTH-1:0] err_count
);
  // Counter only ever needs to reach TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [BE_WIDTH-1:0]     sel_q;
  logic                    we_q;
  logic                    cyc_q;
  logic                    wait_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;
  logic [TW-1:0]           tmo_q;
  logic [ERRCNT_WIDTH-1:0] errcnt_q, errcnt_d;
  logic                    req, tmo_hit;

  assign req      = bus.avmm_chipselect & (bus.avmm_read | bus.avmm_write);
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign errcnt_d = (&errcnt_q) ? errcnt_q : errcnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      cyc_q    <= 1'b0;
      wait_q   <= 1'b1;
      rdata_q  <= '0;
      resp_q   <= 2'b00;
      tmo_q    <= '0;
      errcnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_q <= 1'b1;
          if (req) begin
            adr_q   <= bus.avmm_address;
            dat_q   <= bus.avmm_writedata;
            sel_q   <= bus.avmm_byteenable;
            we_q    <= bus.avmm_write;   // read+write together resolves to a write
            cyc_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= BUS;
          end
        end
        BUS: begin
          if (bus.ack_i) begin
            cyc_q   <= 1'b0;
            if (!we_q) rdata_q <= bus.data_i;
            resp_q  <= 2'b00;
            wait_q  <= 1'b0;
            state_q <= DONE;
          end else if (bus.err_i || tmo_hit) begin
            cyc_q    <= 1'b0;
            rdata_q  <= '0;
            resp_q   <= bus.err_i ? 2'b10 : 2'b11;
            errcnt_q <= errcnt_d;
            wait_q   <= 1'b0;
            state_q  <= DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        DONE: begin
          wait_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.adr_o            = adr_q;
  assign bus.data_o           = dat_q;
  assign bus.sel_o            = sel_q;
  assign bus.we_o             = we_q;
  assign bus.cyc_o            = cyc_q;
  assign bus.stb_o            = cyc_q;
  assign bus.avmm_waitrequest = wait_q;
  assign bus.avmm_readdata    = rdata_q;
  assign bus.avmm_response    = resp_q;
  assign err_count            = errcnt_q;
endmodule
